// File: rtl/chess_gfx_pkg.sv
// ---------------------------------------------------------------------------
// chess_gfx_pkg
// Shared types and constants for the chess sprite datapath.
//   piece_t    : 4-bit piece codes (0 empty, 1-6 white P..K, 9-14 black P..K)
//   SQ_PIX     : pixels per square edge (55)
//   BOARD_DIM  : squares per board edge (8)
//   SPRITE_AW  : sprite ROM address width
//   SQ_W       : width of a square index (row*8+col)
// ---------------------------------------------------------------------------
package chess_gfx_pkg;

  typedef enum logic [3:0] {
    PC_EMPTY = 4'd0,
    PC_WP    = 4'd1,
    PC_WN    = 4'd2,
    PC_WB    = 4'd3,
    PC_WR    = 4'd4,
    PC_WQ    = 4'd5,
    PC_WK    = 4'd6,
    PC_BP    = 4'd9,
    PC_BN    = 4'd10,
    PC_BB    = 4'd11,
    PC_BR    = 4'd12,
    PC_BQ    = 4'd13,
    PC_BK    = 4'd14
  } piece_t;

  localparam int SQ_PIX    = 55;
  localparam int BOARD_DIM = 8;
  localparam int SPRITE_AW = 12;
  localparam int SQ_W      = 6;

  // Square index as stored in the board array: row in the upper bits.
  function automatic logic [SQ_W-1:0] sq_index(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/chess_sprite_sequencer_tile_axis_counter.sv
// ---------------------------------------------------------------------------
// tile_axis_counter
// Walks one raster axis across the board: an offset inside the current square
// (0..54) and the square index along the axis (0..7). Used for X (stepped
// every pixel) and for Y (stepped on each line change).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : restart at square 0 / offset 0 and become active
//   step_i        : advance one pixel/line while active
//   off_o         : offset within the current square
//   idx_o         : square index along the axis
//   active_o      : axis is inside the board
// ---------------------------------------------------------------------------
module tile_axis_counter
  import chess_gfx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       step_i,
  output logic [5:0] off_o,
  output logic [2:0] idx_o,
  output logic       active_o
);

  logic [5:0] off_q, off_d;
  logic [2:0] idx_q, idx_d;
  logic       active_q, active_d;

  // Load wins over step; stepping past the last offset of the last square
  // drops active until the next load.
  always_comb begin
    off_d    = off_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (load_i) begin
      off_d    = '0;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (step_i && active_q) begin
      if (off_q == 6'(SQ_PIX - 1)) begin
        off_d = '0;
        if (idx_q == 3'(BOARD_DIM - 1)) begin
          idx_d    = '0;
          active_d = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        off_d = off_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      off_q    <= off_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign off_o    = off_q;
  assign idx_o    = idx_q;
  assign active_o = active_q;

endmodule

// File: rtl/chess_sprite_sequencer.sv
// ---------------------------------------------------------------------------
// chess_sprite_sequencer
// Per-pixel sequencer for the chess sprite datapath. Stage 1 tracks the raster
// over the 8x8 board with counters; stage 2 reads the 64-entry board and forms
// the sprite ROM address. All outputs refer to the DrawX/DrawY/blank sampled
// two cycles earlier. Board writes are accepted only in vertical blank.
// Optional feature macro: CURSOR_HILITE_EN (cursor square highlight).
// Ports:
//   vga_clk, reset_n       : pixel clock, async active-low reset
//   DrawX, DrawY, blank    : raster position, blank=1 means active video
//   wr_valid/square/piece  : board write request; wr_ready accepts it
//   cursor_sq              : highlighted square (CURSOR_HILITE_EN only)
//   rom_addr               : y_off*55 + x_off within the sprite
//   piece_code             : board content of the current square
//   in_board, sq_dark      : inside board / (row+col) odd (0 outside board)
//   hilite                 : current square equals cursor_sq
//   blank_out              : blank aligned with the other outputs
// ---------------------------------------------------------------------------
module chess_sprite_sequencer
  import chess_gfx_pkg::*;
#(
  parameter int BOARD_X0 = 100,
  parameter int BOARD_Y0 = 20,
  parameter int V_ACTIVE = 480
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 blank,
  input  logic                 wr_valid,
  input  logic [SQ_W-1:0]      wr_square,
  input  logic [3:0]           wr_piece,
  output logic                 wr_ready,
  input  logic [SQ_W-1:0]      cursor_sq,
  output logic [SPRITE_AW-1:0] rom_addr,
  output logic [3:0]           piece_code,
  output logic                 in_board,
  output logic                 sq_dark,
  output logic                 hilite,
  output logic                 blank_out
);

  logic [9:0] drawy_q;
  logic       blank1_q;
  logic       wr_ready_q;
  logic       line_chg;

  logic [5:0] x_off, y_off;
  logic [2:0] col, row;
  logic       x_active, row_lock;

  piece_t     board_q [BOARD_DIM*BOARD_DIM];

  logic                 in_board_d, in_board_q;
  logic [SPRITE_AW-1:0] rom_addr_d, rom_addr_q;
  piece_t               piece_d, piece_q;
  logic                 dark_d, dark_q;
  logic                 blank2_q;
  logic [SQ_W-1:0]      sq_idx;

  assign line_chg = (DrawY != drawy_q);

  tile_axis_counter u_x_axis (
    .clk_i    (vga_clk),
    .rst_ni   (reset_n),
    .load_i   (DrawX == 10'(BOARD_X0)),
    .step_i   (1'b1),
    .off_o    (x_off),
    .idx_o    (col),
    .active_o (x_active)
  );

  // The Y axis only moves on line changes, so its active flag doubles as the
  // row lock; after reset it stays clear until the raster reaches BOARD_Y0.
  tile_axis_counter u_y_axis (
    .clk_i    (vga_clk),
    .rst_ni   (reset_n),
    .load_i   (DrawY == 10'(BOARD_Y0)),
    .step_i   (line_chg),
    .off_o    (y_off),
    .idx_o    (row),
    .active_o (row_lock)
  );

  // Stage 1 side registers: line-change reference, blank, and the write
  // window, which opens only once the raster is in vertical blank.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      drawy_q    <= '0;
      blank1_q   <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      drawy_q    <= DrawY;
      blank1_q   <= blank;
      wr_ready_q <= (DrawY >= 10'(V_ACTIVE));
    end
  end

  // Board writes land only during vblank, so the active frame never sees a
  // square change under it.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BOARD_DIM*BOARD_DIM; i++) begin
        board_q[i] <= PC_EMPTY;
      end
    end else if (wr_valid && wr_ready_q) begin
      board_q[wr_square] <= piece_t'(wr_piece);
    end
  end

  // Stage 2 next-state: everything is forced to 0 outside the board so the
  // pixel mux can use in_board alone to pick the background.
  always_comb begin
    sq_idx     = sq_index(row, col);
    in_board_d = x_active & row_lock & blank1_q;
    rom_addr_d = '0;
    piece_d    = PC_EMPTY;
    dark_d     = 1'b0;
    if (in_board_d) begin
      rom_addr_d = SPRITE_AW'(y_off) * SPRITE_AW'(SQ_PIX) + SPRITE_AW'(x_off);
      piece_d    = board_q[sq_idx];
      dark_d     = row[0] ^ col[0];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_board_q <= 1'b0;
      rom_addr_q <= '0;
      piece_q    <= PC_EMPTY;
      dark_q     <= 1'b0;
      blank2_q   <= 1'b0;
    end else begin
      in_board_q <= in_board_d;
      rom_addr_q <= rom_addr_d;
      piece_q    <= piece_d;
      dark_q     <= dark_d;
      blank2_q   <= blank1_q;
    end
  end

`ifdef CURSOR_HILITE_EN
  logic hilite_q;

  // Cursor highlight, registered alongside the rest of stage 2.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hilite_q <= 1'b0;
    end else begin
      hilite_q <= in_board_d & (sq_idx == cursor_sq);
    end
  end

  assign hilite = hilite_q;
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor_sq;
  assign hilite        = 1'b0;
`endif

  assign wr_ready   = wr_ready_q;
  assign in_board   = in_board_q;
  assign rom_addr   = rom_addr_q;
  assign piece_code = piece_q;
  assign sq_dark    = dark_q;
  assign blank_out  = blank2_q;

endmodule

// File: tb/tb_chess_sprite_sequencer.sv
// ---------------------------------------------------------------------------
// tb_chess_sprite_sequencer
// Directed bench for chess_sprite_sequencer. The raster is compressed: lines
// that are not inspected get a single pixel, inspected lines are swept from
// column 98 up to one pixel past the target so the two-cycle pipeline has
// delivered the target pixel when it is checked.
// ---------------------------------------------------------------------------
module tb_chess_sprite_sequencer;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic        wr_valid;
  logic [5:0]  wr_square;
  logic [3:0]  wr_piece;
  logic        wr_ready;
  logic [5:0]  cursor_sq;
  logic [11:0] rom_addr;
  logic [3:0]  piece_code;
  logic        in_board, sq_dark, hilite, blank_out;

  int errors = 0;
  int checks = 0;
  int curX   = 0;
  int curY   = 0;

`ifdef CURSOR_HILITE_EN
  localparam bit HL_EN = 1'b1;
`else
  localparam bit HL_EN = 1'b0;
`endif

  typedef struct {
    int          x;
    int          y;
    logic        ib;
    logic [11:0] rom;
    logic [3:0]  piece;
    logic        dark;
    logic        hl;
  } vec_t;

  vec_t vecs [17];

  chess_sprite_sequencer dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .wr_valid   (wr_valid),
    .wr_square  (wr_square),
    .wr_piece   (wr_piece),
    .wr_ready   (wr_ready),
    .cursor_sq  (cursor_sq),
    .rom_addr   (rom_addr),
    .piece_code (piece_code),
    .in_board   (in_board),
    .sq_dark    (sq_dark),
    .hilite     (hilite),
    .blank_out  (blank_out)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Drive one raster pixel and let it be sampled.
  task automatic applyStimulus(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = (x < 640) && (y < 480);
    tick();
    curX = x;
    curY = y;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Step line by line (wrapping after 524) until DrawY == y.
  task automatic gotoLine(input int y);
    if (curY != y) begin
      while (curY != y) applyStimulus(0, (curY == 524) ? 0 : curY + 1);
      curX = 97;
    end
  endtask

  task automatic sweepTo(input int x);
    for (int i = curX + 1; i <= x; i++) applyStimulus(i, curY);
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      gotoLine(vecs[i].y);
      sweepTo(vecs[i].x + 1);
      checkOutput($sformatf("v%0d(%0d,%0d) in_board", i, vecs[i].x, vecs[i].y), 12'(in_board), 12'(vecs[i].ib));
      checkOutput($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].rom);
      checkOutput($sformatf("v%0d blank_out", i), 12'(blank_out), 12'd1);
      checkOutput($sformatf("v%0d hilite", i), 12'(hilite), 12'(HL_EN ? vecs[i].hl : 1'b0));
      if (vecs[i].ib) begin
        checkOutput($sformatf("v%0d piece_code", i), 12'(piece_code), 12'(vecs[i].piece));
        checkOutput($sformatf("v%0d sq_dark", i), 12'(sq_dark), 12'(vecs[i].dark));
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " in_board"},   12'(in_board),   12'd0);
    checkOutput({tag, " rom_addr"},   rom_addr,        12'd0);
    checkOutput({tag, " piece_code"}, 12'(piece_code), 12'd0);
    checkOutput({tag, " sq_dark"},    12'(sq_dark),    12'd0);
    checkOutput({tag, " hilite"},     12'(hilite),     12'd0);
    checkOutput({tag, " blank_out"},  12'(blank_out),  12'd0);
    checkOutput({tag, " wr_ready"},   12'(wr_ready),   12'd0);
  endtask

  initial begin
    //               x    y    ib    rom       piece  dark  hl
    // frame 1, empty board
    vecs[0]  = '{ 99,  20, 1'b0, 12'd0,    4'd0,  1'b0, 1'b0};
    vecs[1]  = '{100,  20, 1'b1, 12'd0,    4'd0,  1'b0, 1'b0};
    vecs[2]  = '{154,  20, 1'b1, 12'd54,   4'd0,  1'b0, 1'b0};
    vecs[3]  = '{155,  20, 1'b1, 12'd0,    4'd0,  1'b1, 1'b0};
    vecs[4]  = '{539,  20, 1'b1, 12'd54,   4'd0,  1'b1, 1'b0};
    vecs[5]  = '{540,  20, 1'b0, 12'd0,    4'd0,  1'b0, 1'b0};
    vecs[6]  = '{275, 135, 1'b1, 12'd285,  4'd0,  1'b1, 1'b1};
    // frame 1 after the refused mid-frame write to square 59
    vecs[7]  = '{300, 430, 1'b1, 12'd1410, 4'd0,  1'b0, 1'b0};
    vecs[8]  = '{539, 459, 1'b1, 12'd3024, 4'd0,  1'b0, 1'b0};
    vecs[9]  = '{100, 460, 1'b0, 12'd0,    4'd0,  1'b0, 1'b0};
    // frame 2, after vblank writes sq59=12 and sq19=6
    vecs[10] = '{100,  20, 1'b1, 12'd0,    4'd0,  1'b0, 1'b0};
    vecs[11] = '{275, 135, 1'b1, 12'd285,  4'd6,  1'b1, 1'b1};
    vecs[12] = '{300, 430, 1'b1, 12'd1410, 4'd12, 1'b0, 1'b0};
    // frame 3 before the mid-frame reset
    vecs[13] = '{200, 200, 1'b1, 12'd870,  4'd0,  1'b0, 1'b0};
    // after the reset: locked out until next frame, board cleared
    vecs[14] = '{300, 300, 1'b0, 12'd0,    4'd0,  1'b0, 1'b0};
    vecs[15] = '{100,  20, 1'b1, 12'd0,    4'd0,  1'b0, 1'b0};
    vecs[16] = '{275, 135, 1'b1, 12'd285,  4'd0,  1'b1, 1'b1};

    reset_n   = 1'b0;
    DrawX     = '0;
    DrawY     = '0;
    blank     = 1'b1;
    wr_valid  = 1'b0;
    wr_square = '0;
    wr_piece  = '0;
    cursor_sq = 6'd19;
    repeat (3) tick();
    checkAllZero("reset");
    reset_n = 1'b1;
    curX = 0;
    curY = 0;

    runVectors(0, 6);

    // Write request in active video must not be accepted.
    gotoLine(300);
    wr_valid  = 1'b1;
    wr_square = 6'd59;
    wr_piece  = 4'd12;
    sweepTo(110);
    checkOutput("ready_midframe", 12'(wr_ready), 12'd0);

    runVectors(7, 9);

    // Vblank: the held request is accepted, then a second write.
    gotoLine(480);
    checkOutput("ready_vblank", 12'(wr_ready), 12'd1);
    gotoLine(481);
    wr_square = 6'd19;
    wr_piece  = 4'd6;
    gotoLine(482);
    wr_valid = 1'b0;
    checkOutput("blank_out_vblank", 12'(blank_out), 12'd0);

    runVectors(10, 13);

    // Asynchronous reset in the middle of the board.
    reset_n = 1'b0;
    #1;
    checkAllZero("midreset");
    tick();
    reset_n = 1'b1;

    runVectors(14, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
